// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: state encodings, opcodes, ALU select bits and decode record
// shared by the fetch/execute control unit and its opcode decoder.
package instr_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T1W  = 4'd3,
      ST_T2   = 4'd4,
      ST_T3   = 4'd5,
      ST_T4   = 4'd6,
      ST_T5   = 4'd7,
      ST_T6   = 4'd8,
      ST_HALT = 4'd9
   } state_e;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int ALU_ADD = 0;
   localparam int ALU_SUB = 1;
   localparam int ALU_AND = 5;
   localparam int ALU_OR  = 6;
   localparam int ALU_MUL = 8;
   localparam int ALU_DIV = 9;
   localparam int ALU_NEG = 10;
   localparam int ALU_NOT = 11;

   typedef struct packed {
      logic [11:0] alu_sel;
      logic        is_alu;
      logic        is_hilo;
      logic        is_nop;
      logic        is_halt;
      logic        is_illegal;
   } decode_t;

   function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

endpackage

// File: rtl/instr_sequencer_op_decode.sv
// op_decode: combinational opcode classifier producing the ALU one-hot select
// and the instruction class flags used by the sequencer.
module op_decode
   import instr_sequencer_pkg::*;
(
   input  logic [4:0] opcode_i,
   output decode_t    dec_o
);

   always_comb begin
      dec_o = '0;
      case (opcode_i)
         OP_ADD:  dec_o.alu_sel[ALU_ADD] = 1'b1;
         OP_SUB:  dec_o.alu_sel[ALU_SUB] = 1'b1;
         OP_AND:  dec_o.alu_sel[ALU_AND] = 1'b1;
         OP_OR:   dec_o.alu_sel[ALU_OR]  = 1'b1;
         OP_MUL:  dec_o.alu_sel[ALU_MUL] = 1'b1;
         OP_DIV:  dec_o.alu_sel[ALU_DIV] = 1'b1;
         OP_NEG:  dec_o.alu_sel[ALU_NEG] = 1'b1;
         OP_NOT:  dec_o.alu_sel[ALU_NOT] = 1'b1;
         default: dec_o.alu_sel = '0;
      endcase
      dec_o.is_alu     = |dec_o.alu_sel;
      dec_o.is_hilo    = dec_o.alu_sel[ALU_MUL] | dec_o.alu_sel[ALU_DIV];
      dec_o.is_nop     = opcode_i == OP_NOP;
      dec_o.is_halt    = opcode_i == OP_HALT;
      dec_o.is_illegal = !(dec_o.is_alu || dec_o.is_nop || dec_o.is_halt);
   end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: hardwired fetch/execute control unit driving every strobe of
// the bus datapath; outputs are a Moore decode of the state plus live ir fields.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter bit RST_PC_HOLD = 1'b0
) (
   input  logic        clock,
   input  logic        clr,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic [15:0] reg_in,
   output logic [15:0] reg_out,
   output logic        PCout,
   output logic        MARin,
   output logic        incPC,
   output logic        PCin,
   output logic        MDRread,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlow_in,
   output logic        Zhigh_in,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic [11:0] ALUin,
   output logic        done,
   output logic        illegal,
   output logic        halted
);

   localparam state_e RST_STATE = RST_PC_HOLD ? ST_IDLE : ST_T0;

   state_e     state_q, state_d;
   logic       clr_q;
   decode_t    dec;
   logic [3:0] ra, rb, rc;
   logic       is_unary;
   logic       unused_ir;

   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign is_unary  = dec.alu_sel[ALU_NEG] | dec.alu_sel[ALU_NOT];
   assign unused_ir = ^ir[14:0];

   op_decode u_op_decode (
      .opcode_i (ir[31:27]),
      .dec_o    (dec)
   );

   // clr_q marks the first cycle after clr: outputs stay quiet and T0 is held so
   // the PC is fetched with full strobes on the following cycle.
   always_ff @(posedge clock) begin
      if (clr) state_q <= RST_STATE;
      else     state_q <= state_d;
      clr_q <= clr;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = run ? ST_T0 : ST_IDLE;
         ST_T0:   state_d = ST_T1;
         ST_T1:   state_d = mem_ready ? ST_T2 : ST_T1W;
         ST_T1W:  state_d = mem_ready ? ST_T2 : ST_T1W;
         ST_T2:   state_d = ST_T3;
         ST_T3:   state_d = dec.is_halt ? ST_HALT : dec.is_alu ? ST_T4 : run ? ST_T0 : ST_IDLE;
         ST_T4:   state_d = ST_T5;
         ST_T5:   state_d = dec.is_hilo ? ST_T6 : run ? ST_T0 : ST_IDLE;
         ST_T6:   state_d = run ? ST_T0 : ST_IDLE;
         ST_HALT: state_d = ST_HALT;
         default: state_d = RST_STATE;
      endcase
      if (clr_q && !RST_PC_HOLD) state_d = ST_T0;
   end

   always_comb begin
      reg_in   = '0;
      reg_out  = '0;
      PCout    = 1'b0;
      MARin    = 1'b0;
      incPC    = 1'b0;
      PCin     = 1'b0;
      MDRread  = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zlow_in  = 1'b0;
      Zhigh_in = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      ALUin    = '0;
      done     = 1'b0;
      illegal  = 1'b0;
      halted   = 1'b0;
      if (!clr_q) begin
         case (state_q)
            ST_T0: begin
               PCout   = 1'b1;
               MARin   = 1'b1;
               incPC   = 1'b1;
               Zlow_in = 1'b1;
            end
            ST_T1: begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
               MDRread = 1'b1;
               MDRin   = 1'b1;
            end
            ST_T1W: begin
               MDRread = 1'b1;
               MDRin   = 1'b1;
            end
            ST_T2: begin
               MDRout = 1'b1;
               IRin   = 1'b1;
            end
            ST_T3: begin
               if (dec.is_alu) begin
                  reg_out = reg_onehot(is_unary ? rc : rb);
                  Yin     = 1'b1;
               end else if (!dec.is_halt) begin
                  done    = 1'b1;
                  illegal = dec.is_illegal;
               end
            end
            ST_T4: begin
               reg_out  = reg_onehot(rc);
               ALUin    = dec.alu_sel;
               Zlow_in  = 1'b1;
               Zhigh_in = 1'b1;
            end
            ST_T5: begin
               Zlowout = 1'b1;
               LOin    = dec.is_hilo;
               reg_in  = dec.is_hilo ? 16'h0000 : reg_onehot(ra);
               done    = !dec.is_hilo;
            end
            ST_T6: begin
               Zhighout = 1'b1;
               HIin     = 1'b1;
               done     = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: halted = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: instruction-level reference expands each instruction into its
// expected per-cycle strobe vectors; a negedge monitor pops and compares them.
module tb_instr_sequencer;

   logic        clock = 1'b0;
   logic        clr, run, mem_ready;
   logic [31:0] ir;
   logic [15:0] reg_in, reg_out;
   logic        PCout, MARin, incPC, PCin, MDRread, MDRin, MDRout, IRin, Yin;
   logic        Zlow_in, Zhigh_in, Zlowout, Zhighout, HIin, LOin;
   logic [11:0] ALUin;
   logic        done, illegal, halted;

   always #5 clock = ~clock;

   instr_sequencer #(.RST_PC_HOLD(1'b0)) dut (
      .clock(clock), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
      .reg_in(reg_in), .reg_out(reg_out),
      .PCout(PCout), .MARin(MARin), .incPC(incPC), .PCin(PCin),
      .MDRread(MDRread), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
      .Zlow_in(Zlow_in), .Zhigh_in(Zhigh_in), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .HIin(HIin), .LOin(LOin), .ALUin(ALUin),
      .done(done), .illegal(illegal), .halted(halted)
   );

   localparam logic [14:0] S_PCOUT = 15'h4000, S_MARIN = 15'h2000, S_INCPC = 15'h1000;
   localparam logic [14:0] S_PCIN  = 15'h0800, S_MDRRD = 15'h0400, S_MDRIN = 15'h0200;
   localparam logic [14:0] S_MDROUT = 15'h0100, S_IRIN = 15'h0080, S_YIN = 15'h0040;
   localparam logic [14:0] S_ZLIN  = 15'h0020, S_ZHIN  = 15'h0010, S_ZLOUT = 15'h0008;
   localparam logic [14:0] S_ZHOUT = 15'h0004, S_HIIN  = 15'h0002, S_LOIN  = 15'h0001;

   localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b01001, OR_ = 5'b01010;
   localparam logic [4:0] MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001, NOT_ = 5'b10010;
   localparam logic [4:0] NOP = 5'b11000, HLT = 5'b11011;

   typedef logic [61:0] vec_t;
   localparam vec_t ZERO = '0;

   function automatic vec_t mk(input logic [15:0] ri, input logic [15:0] ro, input logic [14:0] s,
                               input logic [11:0] alu, input bit d, input bit il, input bit h);
      return {ri, ro, s, alu, d, il, h};
   endfunction

   vec_t act;
   assign act = {reg_in, reg_out, PCout, MARin, incPC, PCin, MDRread, MDRin, MDRout, IRin, Yin,
                 Zlow_in, Zhigh_in, Zlowout, Zhighout, HIin, LOin, ALUin, done, illegal, halted};

   vec_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   always @(negedge clock) begin
      vec_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL strobes t=%0t got=%h want=%h", $time, act, e);
         end
         if ((|reg_in) && (|reg_out)) begin
            bad++;
            $display("FAIL reg_in_and_reg_out t=%0t got=%h/%h want one zero", $time, reg_in, reg_out);
         end
      end
   end

   task automatic cyc(input vec_t e);
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic do_clr(input vec_t cur);
      clr = 1'b1;
      cyc(cur);
      clr = 1'b0;
      cyc(ZERO);
   endtask

   function automatic logic [11:0] alu_code(input logic [4:0] op);
      case (op)
         ADD:     return 12'h001;
         SUB:     return 12'h002;
         AND_:    return 12'h020;
         OR_:     return 12'h040;
         MUL:     return 12'h100;
         DIV:     return 12'h200;
         NEG:     return 12'h400;
         NOT_:    return 12'h800;
         default: return 12'h000;
      endcase
   endfunction

   task automatic do_instr(input logic [31:0] instr, input int waits, input bit end_run, input int abort_at);
      vec_t        plan[$];
      bit          mr[$];
      logic [4:0]  op;
      logic [3:0]  ra, rb, rc;
      logic [11:0] code;
      bit          hilo, unary;
      op    = instr[31:27];
      ra    = instr[26:23];
      rb    = instr[22:19];
      rc    = instr[18:15];
      code  = alu_code(op);
      hilo  = (op == MUL) || (op == DIV);
      unary = (op == NEG) || (op == NOT_);
      plan.push_back(mk(0, 0, S_PCOUT | S_MARIN | S_INCPC | S_ZLIN, 0, 0, 0, 0));
      mr.push_back(1'($urandom));
      plan.push_back(mk(0, 0, S_ZLOUT | S_PCIN | S_MDRRD | S_MDRIN, 0, 0, 0, 0));
      mr.push_back(waits == 0);
      for (int i = 0; i < waits; i++) begin
         plan.push_back(mk(0, 0, S_MDRRD | S_MDRIN, 0, 0, 0, 0));
         mr.push_back(i == waits - 1);
      end
      plan.push_back(mk(0, 0, S_MDROUT | S_IRIN, 0, 0, 0, 0));
      mr.push_back(1'($urandom));
      if (op == HLT) begin
         plan.push_back(ZERO);
      end else if (code == 0) begin
         plan.push_back(mk(0, 0, 0, 0, 1, op != NOP, 0));
      end else begin
         plan.push_back(mk(0, 16'h1 << (unary ? rc : rb), S_YIN, 0, 0, 0, 0));
         plan.push_back(mk(0, 16'h1 << rc, S_ZLIN | S_ZHIN, code, 0, 0, 0));
         if (hilo) begin
            plan.push_back(mk(0, 0, S_ZLOUT | S_LOIN, 0, 0, 0, 0));
            plan.push_back(mk(0, 0, S_ZHOUT | S_HIIN, 0, 1, 0, 0));
         end else begin
            plan.push_back(mk(16'h1 << ra, 0, S_ZLOUT, 0, 1, 0, 0));
         end
      end
      while (mr.size() < plan.size()) mr.push_back(1'($urandom));
      ir = instr;
      for (int i = 0; i < plan.size(); i++) begin
         mem_ready = mr[i];
         run = (i == plan.size() - 1) ? end_run : 1'($urandom);
         if (i == abort_at) begin
            do_clr(plan[i]);
            return;
         end
         cyc(plan[i]);
      end
      if (op == HLT) begin
         repeat ($urandom_range(2, 5)) begin
            run = 1'($urandom);
            mem_ready = 1'($urandom);
            cyc(mk(0, 0, 0, 0, 0, 0, 1));
         end
         do_clr(mk(0, 0, 0, 0, 0, 0, 1));
      end else if (!end_run) begin
         repeat ($urandom_range(0, 3)) begin
            run = 1'b0;
            cyc(ZERO);
         end
         run = 1'b1;
         cyc(ZERO);
      end
   endtask

   logic [4:0] ops [10] = '{ADD, SUB, AND_, OR_, MUL, DIV, NEG, NOT_, NOP, HLT};

   initial begin
      logic [31:0] r;
      clr = 1'b1;
      run = 1'b0;
      mem_ready = 1'b0;
      ir = '0;
      @(posedge clock);
      #1;
      cyc(ZERO);
      clr = 1'b0;
      cyc(ZERO);
      do_instr(32'h4A920000, 0, 1'b1, -1);
      do_instr(32'h78188000, 0, 1'b1, -1);
      do_instr(32'h4A920000, 3, 1'b1, -1);
      do_instr(32'h4A920000, 0, 1'b1, 4);
      do_instr({5'b11111, 27'h5A5A5A5}, 0, 1'b1, -1);
      do_instr(32'h4A920000, 0, 1'b0, -1);
      do_instr({NEG, 4'd7, 4'd3, 4'd9, 15'h0}, 1, 1'b1, -1);
      do_instr({DIV, 4'd0, 4'd15, 4'd14, 15'h0}, 2, 1'b0, -1);
      do_instr({NOP, 27'h0}, 0, 1'b1, -1);
      do_instr({HLT, 27'h0}, 0, 1'b1, -1);
      for (int n = 0; n < 300; n++) begin
         r = $urandom;
         if ($urandom_range(0, 7) != 0) r[31:27] = ops[$urandom_range(0, 9)];
         do_instr(r, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0, 1'($urandom),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
      end
      do_instr(32'h4A920000, 0, 1'b0, -1);
      @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0 pending", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
